rhd_cmd_sequencer: RTL

RHD_CMD_SEQUENCER -- requirements
Module: rhd_cmd_sequencer

---
 rtl/rhd_seq_pkg.sv | 19 +
 rtl/rhd_aux_cmd_ram.sv | 46 ++++
 rtl/rhd_cmd_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rhd_seq_pkg.sv
// Shared types and constants for the RHD command sequencer.
// Optional aux command lists are enabled by defining RHD_SEQ_AUX_EN.
package rhd_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } seq_state_e;

    localparam logic [1:0]  OpConvert = 2'b00;
    localparam int unsigned SlotW     = 7;
    localparam int unsigned CmdW      = 16;

    function automatic logic [CmdW-1:0] convert_cmd(input logic [5:0] ch, input logic h);
        return {OpConvert, ch, 7'b0, h};
    endfunction

endpackage

// File: rtl/rhd_aux_cmd_ram.sv
// Auxiliary command storage: NUM_AUX lists of AUX_DEPTH 16-bit words, one write port,
// one combinational read port, cleared by reset. Used only when RHD_SEQ_AUX_EN is defined.
module rhd_aux_cmd_ram
    import rhd_seq_pkg::*;
#(
    parameter int unsigned NUM_AUX   = 3,
    parameter int unsigned AUX_DEPTH = 16,
    parameter int unsigned AW        = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wr_en_i,
    input  logic [1:0]      wr_sel_i,
    input  logic [7:0]      wr_addr_i,
    input  logic [CmdW-1:0] wr_data_i,
    input  logic [1:0]      rd_sel_i,
    input  logic [AW-1:0]   rd_addr_i,
    output logic [CmdW-1:0] rd_data_o
);

    localparam int unsigned Entries = NUM_AUX * AUX_DEPTH;
    localparam int unsigned IdxW    = (Entries > 1) ? $clog2(Entries) : 1;

    logic [CmdW-1:0] mem_q [Entries];
    logic            wr_ok;
    logic [IdxW-1:0] wr_idx;
    logic [IdxW-1:0] rd_idx;

    // Writes to a nonexistent list or past the end of a list are dropped.
    assign wr_ok  = wr_en_i && (32'(wr_sel_i) < NUM_AUX) && (32'(wr_addr_i) < AUX_DEPTH);
    assign wr_idx = IdxW'(wr_sel_i) * IdxW'(AUX_DEPTH) + IdxW'(wr_addr_i);
    assign rd_idx = IdxW'(rd_sel_i) * IdxW'(AUX_DEPTH) + IdxW'(rd_addr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Entries; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_idx] <= wr_data_i;
        end
    end

    assign rd_data_o = (32'(rd_sel_i) < NUM_AUX) ? mem_q[rd_idx] : '0;

endmodule

// File: rtl/rhd_cmd_sequencer.sv
// Frame sequencer feeding RHD command words to an SPI engine: NUM_CH CONVERT slots,
// followed by one word from each aux list when RHD_SEQ_AUX_EN is defined.
module rhd_cmd_sequencer
    import rhd_seq_pkg::*;
#(
    parameter int unsigned NUM_CH    = 32,
    parameter int unsigned NUM_AUX   = 3,
    parameter int unsigned AUX_DEPTH = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 fast_settle,
    input  logic [15:0]          batch_len,
    input  logic [NUM_AUX*8-1:0] aux_last,
    input  logic                 aux_wr_en,
    input  logic [1:0]           aux_wr_sel,
    input  logic [7:0]           aux_wr_addr,
    input  logic [15:0]          aux_wr_data,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [15:0]          cmd_data,
    output logic [6:0]           cmd_slot,
    output logic                 frame_start,
    output logic                 batch_done,
    output logic                 busy,
    output logic [31:0]          frame_cnt
);

`ifdef RHD_SEQ_AUX_EN
    localparam int unsigned NumSlots = NUM_CH + NUM_AUX;
`else
    localparam int unsigned NumSlots = NUM_CH;
`endif
    localparam logic [SlotW-1:0] LastSlot = SlotW'(NumSlots - 1);

    seq_state_e       state_q;
    logic [SlotW-1:0] slot_q;
    logic [CmdW-1:0]  cmd_data_q;
    logic             cmd_valid_q;
    logic             h_q;
    logic             frame_start_q;
    logic             batch_done_q;
    logic [31:0]      frame_cnt_q;
    logic [15:0]      batch_len_q;
    logic [15:0]      batch_cnt_q;

    logic             hs;
    logic             start_acq;
    logic             frame_h;
    logic [SlotW-1:0] next_slot;
    logic [CmdW-1:0]  next_word;

    assign hs        = cmd_valid_q && cmd_ready;
    assign start_acq = (state_q == StIdle) && start && !stop;
    assign next_slot = (slot_q == LastSlot) ? '0 : slot_q + 1'b1;
    // H for the rest of the frame is whatever fast_settle reads at the slot-0 handshake.
    assign frame_h   = (slot_q == '0) ? fast_settle : h_q;

`ifdef RHD_SEQ_AUX_EN
    localparam int unsigned AuxAw = (AUX_DEPTH > 1) ? $clog2(AUX_DEPTH) : 1;

    logic [AuxAw-1:0] aux_ptr_q [NUM_AUX];
    logic [AuxAw-1:0] aux_lim   [NUM_AUX];
    logic             rd_is_aux;
    logic             hs_is_aux;
    logic [1:0]       rd_sel;
    logic [1:0]       hs_sel;
    logic [AuxAw-1:0] rd_addr;
    logic [CmdW-1:0]  aux_rd_data;

    always_comb begin
        for (int i = 0; i < NUM_AUX; i++) begin
            if ({1'b0, aux_last[i*8 +: 8]} >= 9'(AUX_DEPTH)) begin
                aux_lim[i] = AuxAw'(AUX_DEPTH - 1);
            end else begin
                aux_lim[i] = aux_last[i*8 +: AuxAw];
            end
        end
    end

    assign rd_is_aux = next_slot >= SlotW'(NUM_CH);
    assign hs_is_aux = slot_q >= SlotW'(NUM_CH);
    assign rd_sel    = 2'(next_slot - SlotW'(NUM_CH));
    assign hs_sel    = 2'(slot_q - SlotW'(NUM_CH));
    assign rd_addr   = (rd_is_aux && (32'(rd_sel) < NUM_AUX)) ? aux_ptr_q[rd_sel] : '0;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_AUX; i++) begin
                aux_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_AUX; i++) begin
                if (start_acq) begin
                    aux_ptr_q[i] <= '0;
                end else if (hs && hs_is_aux && (hs_sel == 2'(i))) begin
                    aux_ptr_q[i] <= (aux_ptr_q[i] >= aux_lim[i]) ? '0 : aux_ptr_q[i] + 1'b1;
                end
            end
        end
    end

    rhd_aux_cmd_ram #(
        .NUM_AUX  (NUM_AUX),
        .AUX_DEPTH(AUX_DEPTH),
        .AW       (AuxAw)
    ) u_aux_ram (
        .clk_i    (aclk),
        .rst_i    (areset),
        .wr_en_i  (aux_wr_en),
        .wr_sel_i (aux_wr_sel),
        .wr_addr_i(aux_wr_addr),
        .wr_data_i(aux_wr_data),
        .rd_sel_i (rd_sel),
        .rd_addr_i(rd_addr),
        .rd_data_o(aux_rd_data)
    );
`else
    logic unused_aux;
    assign unused_aux = ^{aux_last, aux_wr_en, aux_wr_sel, aux_wr_addr, aux_wr_data,
                          8'(NUM_AUX), 9'(AUX_DEPTH)};
`endif

    // Word preloaded at each handshake; slot 0 gets its H bit live at the output.
    always_comb begin
        next_word = convert_cmd(next_slot[5:0], frame_h && (next_slot != '0));
`ifdef RHD_SEQ_AUX_EN
        if (rd_is_aux) begin
            next_word = aux_rd_data;
        end
`endif
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= StIdle;
            slot_q        <= '0;
            cmd_data_q    <= '0;
            cmd_valid_q   <= 1'b0;
            h_q           <= 1'b0;
            frame_start_q <= 1'b0;
            batch_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            batch_len_q   <= '0;
            batch_cnt_q   <= '0;
        end else begin
            frame_start_q <= 1'b0;
            batch_done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_acq) begin
                        state_q     <= StRun;
                        cmd_valid_q <= 1'b1;
                        slot_q      <= '0;
                        cmd_data_q  <= convert_cmd(6'd0, 1'b0);
                        h_q         <= 1'b0;
                        frame_cnt_q <= '0;
                        batch_cnt_q <= '0;
                        batch_len_q <= batch_len;
                    end
                end
                StRun, StDrain: begin
                    if ((state_q == StRun) && stop) begin
                        state_q <= StDrain;
                    end
                    if (hs) begin
                        slot_q     <= next_slot;
                        cmd_data_q <= next_word;
                        if (slot_q == '0) begin
                            h_q           <= fast_settle;
                            frame_start_q <= 1'b1;
                        end
                        if (slot_q == LastSlot) begin
                            frame_cnt_q <= frame_cnt_q + 32'd1;
                            if (batch_len_q != '0) begin
                                if (batch_cnt_q + 16'd1 == batch_len_q) begin
                                    batch_done_q <= 1'b1;
                                    batch_cnt_q  <= '0;
                                end else begin
                                    batch_cnt_q <= batch_cnt_q + 16'd1;
                                end
                            end
                            if (state_q == StDrain) begin
                                state_q     <= StIdle;
                                cmd_valid_q <= 1'b0;
                                slot_q      <= '0;
                                cmd_data_q  <= '0;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_data    = (cmd_valid_q && (slot_q == '0)) ? {cmd_data_q[CmdW-1:1], fast_settle}
                                                         : cmd_data_q;
    assign cmd_slot    = slot_q;
    assign frame_start = frame_start_q;
    assign batch_done  = batch_done_q;
    assign busy        = (state_q != StIdle);
    assign frame_cnt   = frame_cnt_q;

endmodule
